// File: rtl/sfft_readout_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sfft_readout_pkg
// Purpose  : Shared FSM states, lock bytes and address helpers for the
//            SFFT readout master.
// Revision : 1.0  initial release
// ============================================================================
package sfft_readout_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOCK     = 3'd1,
        S_RD_TIME  = 3'd2,
        S_RD_BIN   = 3'd3,
        S_PUSH     = 3'd4,
        S_RD_VALID = 3'd5,
        S_RELEASE  = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    localparam logic [7:0] LOCK_BYTE    = 8'h01;
    localparam logic [7:0] RELEASE_BYTE = 8'h00;

    // Frame counter sits directly above the bin region, valid byte after it.
    function automatic logic [15:0] time_base(input int nfft);
        return 16'(nfft * 2);
    endfunction

    function automatic logic [15:0] valid_addr(input int nfft);
        return 16'(nfft * 2 + 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfft_readout_master_asm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : byte_word_assembler
// Purpose  : Walks 4 (or 1) byte addresses from a base while go is held and
//            packs the returned bytes little-endian into a 32-bit word.
// Revision : 1.0  initial release
// ============================================================================
module byte_word_assembler #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        single,
    input  logic [15:0] base,
    input  logic [7:0]  readdata,
    output logic [15:0] address,
    output logic [31:0] word,
    output logic        word_done
);

    // Each byte spends READ_LATENCY+1 cycles on the bus: sample after
    // READ_LATENCY cycles, then one cycle to advance to the next byte.
    localparam logic [1:0] c_lat_last = 2'(READ_LATENCY);
    localparam logic [1:0] c_cap      = 2'(READ_LATENCY - 1);

    logic [1:0]  r_cnt;
    logic [1:0]  r_byte;
    logic [31:0] r_word;
    logic        w_last_byte;

    assign w_last_byte = single | (r_byte == 2'd3);
    assign word_done   = go & (r_cnt == c_lat_last) & w_last_byte;
    assign address     = base + {14'd0, r_byte};
    assign word        = r_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= 2'd0;
            r_byte <= 2'd0;
            r_word <= 32'd0;
        end else begin
            if (go && (r_cnt == c_cap)) begin
                r_word[{r_byte, 3'b000} +: 8] <= readdata;
            end
            if (!go) begin
                r_cnt  <= 2'd0;
                r_byte <= 2'd0;
            end else if (r_cnt == c_lat_last) begin
                r_cnt  <= 2'd0;
                r_byte <= w_last_byte ? 2'd0 : r_byte + 2'd1;
            end else begin
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sfft_readout_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sfft_readout_master
// Purpose  : Locks the SFFT output, reads frame counter, bins and valid byte,
//            streams bins out and retries frames that come back invalid.
// Revision : 1.0  initial release
// ============================================================================
module sfft_readout_master
    import sfft_readout_pkg::*;
#(
    parameter  int NFFT         = 512,
    parameter  int NFFT_LOG2    = 9,
    parameter  int READ_LATENCY = 1,
    parameter  int MAX_RETRIES  = 3,
    localparam int BIN_IDX_W    = NFFT_LOG2 - 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 frame_ok,
    output logic [31:0]          frame_time,
    output logic [15:0]          address,
    output logic                 chipselect,
    output logic                 write,
    output logic [7:0]           writedata,
    input  logic [7:0]           readdata,
    output logic [31:0]          bin_data,
    output logic [BIN_IDX_W-1:0] bin_index,
    output logic                 bin_valid,
    input  logic                 bin_ready,
    output logic                 bin_last
);

    localparam int                   c_retry_w     = $clog2(MAX_RETRIES + 1);
    localparam logic [c_retry_w-1:0] c_max_retries = c_retry_w'(MAX_RETRIES);
    localparam logic [BIN_IDX_W-1:0] c_last_idx    = BIN_IDX_W'(NFFT / 2 - 1);
    localparam logic [15:0]          c_time_base   = time_base(NFFT);
    localparam logic [15:0]          c_valid_addr  = valid_addr(NFFT);

    state_t               r_state, w_next;
    logic [c_retry_w-1:0] r_retries;
    logic [BIN_IDX_W-1:0] r_idx;
    logic                 r_ok;
    logic [31:0]          r_frame_time;

    logic        w_go, w_single, w_word_done;
    logic [15:0] w_base, w_asm_addr;
    logic [31:0] w_word;

    byte_word_assembler #(
        .READ_LATENCY (READ_LATENCY)
    ) u_asm (
        .clk       (clk),
        .reset     (reset),
        .go        (w_go),
        .single    (w_single),
        .base      (w_base),
        .readdata  (readdata),
        .address   (w_asm_addr),
        .word      (w_word),
        .word_done (w_word_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_retries    <= '0;
            r_idx        <= '0;
            r_ok         <= 1'b0;
            r_frame_time <= 32'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_LOCK:     r_idx <= '0;
                S_RD_TIME:  if (w_word_done) r_frame_time <= w_word;
                S_PUSH:     if (bin_ready && (r_idx != c_last_idx))
                                r_idx <= r_idx + BIN_IDX_W'(1);
                S_RD_VALID: if (w_word_done) r_ok <= w_word[0];
                S_RELEASE:  if (!r_ok && (r_retries != c_max_retries))
                                r_retries <= r_retries + c_retry_w'(1);
                S_DONE:     r_retries <= '0;
                default:    ;
            endcase
        end
    end

    always_comb begin
        w_next     = r_state;
        w_go       = 1'b0;
        w_single   = 1'b0;
        w_base     = 16'd0;
        address    = 16'd0;
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = 8'h00;
        bin_valid  = 1'b0;
        done       = 1'b0;
        frame_ok   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LOCK;
            end
            S_LOCK: begin
                chipselect = 1'b1;
                write      = 1'b1;
                writedata  = LOCK_BYTE;
                w_next     = S_RD_TIME;
            end
            S_RD_TIME: begin
                w_go       = 1'b1;
                w_base     = c_time_base;
                chipselect = 1'b1;
                address    = w_asm_addr;
                if (w_word_done) w_next = S_RD_BIN;
            end
            S_RD_BIN: begin
                w_go       = 1'b1;
                w_base     = 16'({r_idx, 2'b00});
                chipselect = 1'b1;
                address    = w_asm_addr;
                if (w_word_done) w_next = S_PUSH;
            end
            S_PUSH: begin
                bin_valid = 1'b1;
                if (bin_ready) w_next = (r_idx == c_last_idx) ? S_RD_VALID : S_RD_BIN;
            end
            S_RD_VALID: begin
                w_go       = 1'b1;
                w_single   = 1'b1;
                w_base     = c_valid_addr;
                chipselect = 1'b1;
                address    = w_asm_addr;
                if (w_word_done) w_next = S_RELEASE;
            end
            S_RELEASE: begin
                chipselect = 1'b1;
                write      = 1'b1;
                writedata  = RELEASE_BYTE;
                // An invalid frame is re-streamed from the lock step.
                w_next     = (r_ok || (r_retries == c_max_retries)) ? S_DONE : S_LOCK;
            end
            S_DONE: begin
                done     = 1'b1;
                frame_ok = r_ok;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign busy       = (r_state != S_IDLE);
    assign frame_time = r_frame_time;
    assign bin_data   = w_word;
    assign bin_index  = r_idx;
    assign bin_last   = bin_valid & (r_idx == c_last_idx);

endmodule
`default_nettype wire

// File: tb/tb_sfft_readout_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sfft_readout_master
// Purpose  : Directed bench with an NFFT=16 accelerator model; one instance at
//            READ_LATENCY=1, one at READ_LATENCY=2.
// Revision : 1.0  initial release
// ============================================================================
module tb_sfft_readout_master;

    localparam int NFFT = 16, NFFT_LOG2 = 4, MAX_RETRIES = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Accelerator memory: bins A0000000+i, counter 1234, valid byte vbit.
    function automatic logic [7:0] acc_byte(input logic [15:0] a, input logic vbit);
        logic [31:0] w;
        if (a < 16'd32)       w = 32'hA000_0000 + 32'(a[15:2]);
        else if (a < 16'd36)  w = 32'h0000_1234;
        else if (a == 16'd36) w = {31'd0, vbit};
        else                  w = 32'd0;
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    // ---------------- instance 1 : READ_LATENCY = 1 ----------------
    logic start1 = 1'b0, br1 = 1'b1;
    logic busy1, done1, fok1, cs1, wr1, bv1, bl1, vbit1;
    logic [31:0] ft1, bd1;
    logic [15:0] addr1;
    logic [7:0]  wd1, rd1;
    logic [2:0]  bi1;
    logic [7:0]  valid_pat = 8'hFF;
    int lock_seen1 = 0, rel_seen1 = 0, done_seen1 = 0;
    logic ok_seen1 = 1'b0;
    logic [7:0]  wq1[$];
    logic [31:0] dq1[$];
    logic [2:0]  iq1[$];
    logic        lq1[$];

    assign vbit1 = (lock_seen1 > 0 && lock_seen1 <= 8) ? valid_pat[lock_seen1 - 1] : 1'b0;
    assign rd1   = acc_byte(addr1, vbit1);

    sfft_readout_master #(.NFFT(NFFT), .NFFT_LOG2(NFFT_LOG2), .READ_LATENCY(1),
                          .MAX_RETRIES(MAX_RETRIES)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .frame_ok(fok1), .frame_time(ft1), .address(addr1), .chipselect(cs1),
        .write(wr1), .writedata(wd1), .readdata(rd1), .bin_data(bd1),
        .bin_index(bi1), .bin_valid(bv1), .bin_ready(br1), .bin_last(bl1));

    always @(negedge clk) begin
        if (!reset) begin
            if (cs1 && wr1) begin
                wq1.push_back(wd1);
                if (wd1 == 8'h01) lock_seen1++;
                else rel_seen1++;
            end
            if (bv1 && br1) begin
                dq1.push_back(bd1);
                iq1.push_back(bi1);
                lq1.push_back(bl1);
            end
            if (done1) begin
                done_seen1++;
                ok_seen1 = fok1;
            end
        end
    end

    // ---------------- instance 2 : READ_LATENCY = 2 ----------------
    logic start2 = 1'b0;
    logic busy2, done2, fok2, cs2, wr2, bv2, bl2;
    logic [31:0] ft2, bd2;
    logic [15:0] addr2, addr2_d = 16'd0;
    logic [7:0]  wd2, rd2;
    logic [2:0]  bi2;
    int lock_seen2 = 0, done_seen2 = 0;
    logic ok_seen2 = 1'b0;
    logic [31:0] dq2[$];

    // Data follows the address one cycle late, so only a 2-cycle sample is right.
    always @(posedge clk) addr2_d <= addr2;
    assign rd2 = acc_byte(addr2_d, 1'b1);

    sfft_readout_master #(.NFFT(NFFT), .NFFT_LOG2(NFFT_LOG2), .READ_LATENCY(2),
                          .MAX_RETRIES(MAX_RETRIES)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .frame_ok(fok2), .frame_time(ft2), .address(addr2), .chipselect(cs2),
        .write(wr2), .writedata(wd2), .readdata(rd2), .bin_data(bd2),
        .bin_index(bi2), .bin_valid(bv2), .bin_ready(1'b1), .bin_last(bl2));

    always @(negedge clk) begin
        if (!reset) begin
            if (cs2 && wr2 && wd2 == 8'h01) lock_seen2++;
            if (bv2) dq2.push_back(bd2);
            if (done2) begin
                done_seen2++;
                ok_seen2 = fok2;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic clear1();
        wq1.delete(); dq1.delete(); iq1.delete(); lq1.delete();
        lock_seen1 = 0; rel_seen1 = 0; done_seen1 = 0; ok_seen1 = 1'b0;
    endtask

    task automatic pulse_start1();
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
    endtask

    task automatic wait_done1(input string tag);
        int n = 0;
        while (done_seen1 == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done_seen"}, 32'(done_seen1 != 0), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frame1(input string tag);
        check_eq({tag, "_nwrites"}, 32'(wq1.size()), 32'd2);
        if (wq1.size() == 2) begin
            check_eq({tag, "_lock_byte"}, 32'(wq1[0]), 32'h01);
            check_eq({tag, "_rel_byte"}, 32'(wq1[1]), 32'h00);
        end
        check_eq({tag, "_nbins"}, 32'(dq1.size()), 32'd8);
        for (int i = 0; i < 8 && i < dq1.size(); i++) begin
            check_eq({tag, "_bin_data"}, dq1[i], 32'hA000_0000 + 32'(i));
            check_eq({tag, "_bin_index"}, 32'(iq1[i]), 32'(i));
            check_eq({tag, "_bin_last"}, 32'(lq1[i]), 32'(i == 7));
        end
        check_eq({tag, "_frame_time"}, ft1, 32'h0000_1234);
        check_eq({tag, "_done_count"}, 32'(done_seen1), 32'd1);
        check_eq({tag, "_frame_ok"}, 32'(ok_seen1), 32'd1);
        check_eq({tag, "_busy_after"}, 32'(busy1), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ctrl1", 32'({busy1, done1, fok1, cs1, wr1, bv1, bl1, bi1, wd1}), 32'd0);
        check_eq("rst_addr1", 32'(addr1), 32'd0);
        check_eq("rst_ft1", ft1, 32'd0);
        check_eq("rst_bd1", bd1, 32'd0);
        check_eq("rst_ctrl2", 32'({busy2, done2, cs2, wr2, bv2}), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Basic frame
        clear1();
        pulse_start1();
        @(negedge clk);
        check_eq("basic_busy", 32'(busy1), 32'd1);
        wait_done1("basic");
        check_frame1("basic");

        // Back-pressure at index 3
        clear1();
        pulse_start1();
        n = 0;
        while (bi1 != 3'd3 && n < 500) begin @(negedge clk); n++; end
        br1 = 1'b0;
        n = 0;
        while (!bv1 && n < 500) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            check_eq("stall_valid", 32'(bv1), 32'd1);
            check_eq("stall_data", bd1, 32'hA000_0003);
            check_eq("stall_index", 32'(bi1), 32'd3);
            check_eq("stall_cs", 32'(cs1), 32'd0);
            if (k < 4) @(negedge clk);
        end
        @(posedge clk); #1 br1 = 1'b1;
        wait_done1("stall");
        check_frame1("stall");

        // Invalid first attempt, valid second
        clear1();
        valid_pat = 8'b0000_0010;
        pulse_start1();
        wait_done1("retry1");
        check_eq("retry1_locks", 32'(lock_seen1), 32'd2);
        check_eq("retry1_releases", 32'(rel_seen1), 32'd2);
        check_eq("retry1_nbins", 32'(dq1.size()), 32'd16);
        if (dq1.size() == 16) begin
            check_eq("retry1_restart_idx", 32'(iq1[8]), 32'd0);
            check_eq("retry1_restart_data", dq1[8], 32'hA000_0000);
        end
        check_eq("retry1_done_count", 32'(done_seen1), 32'd1);
        check_eq("retry1_frame_ok", 32'(ok_seen1), 32'd1);

        // Never valid: 1 + MAX_RETRIES attempts
        clear1();
        valid_pat = 8'h00;
        pulse_start1();
        wait_done1("retryall");
        check_eq("retryall_locks", 32'(lock_seen1), 32'd4);
        check_eq("retryall_releases", 32'(rel_seen1), 32'd4);
        check_eq("retryall_nbins", 32'(dq1.size()), 32'd32);
        check_eq("retryall_done_count", 32'(done_seen1), 32'd1);
        check_eq("retryall_frame_ok", 32'(ok_seen1), 32'd0);

        // Reset while reading bin word 2
        clear1();
        valid_pat = 8'hFF;
        pulse_start1();
        n = 0;
        while (!(bi1 == 3'd2 && cs1 && !wr1) && n < 500) begin @(negedge clk); n++; end
        check_eq("abort_reached_w2", 32'(n < 500), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_eq("abort_ctrl", 32'({busy1, done1, fok1, cs1, wr1, bv1, bl1, bi1, wd1}), 32'd0);
        check_eq("abort_addr", 32'(addr1), 32'd0);
        check_eq("abort_ft", ft1, 32'd0);
        check_eq("abort_bd", bd1, 32'd0);
        repeat (10) @(negedge clk);
        check_eq("abort_no_release", 32'(rel_seen1), 32'd0);
        check_eq("abort_idle", 32'(busy1), 32'd0);
        clear1();
        pulse_start1();
        wait_done1("after_abort");
        check_frame1("after_abort");

        // READ_LATENCY=2 instance, second start while busy is dropped
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        repeat (10) @(posedge clk);
        #1 start2 = 1'b1;
        @(negedge clk);
        check_eq("rl2_busy", 32'(busy2), 32'd1);
        @(posedge clk); #1 start2 = 1'b0;
        n = 0;
        while (done_seen2 == 0 && n < 2000) begin @(negedge clk); n++; end
        check_eq("rl2_done_seen", 32'(done_seen2 != 0), 32'd1);
        repeat (30) @(negedge clk);
        check_eq("rl2_done_count", 32'(done_seen2), 32'd1);
        check_eq("rl2_locks", 32'(lock_seen2), 32'd1);
        check_eq("rl2_idle", 32'(busy2), 32'd0);
        check_eq("rl2_frame_ok", 32'(ok_seen2), 32'd1);
        check_eq("rl2_frame_time", ft2, 32'h0000_1234);
        check_eq("rl2_nbins", 32'(dq2.size()), 32'd8);
        for (int i = 0; i < 8 && i < dq2.size(); i++)
            check_eq("rl2_bin_data", dq2[i], 32'hA000_0000 + 32'(i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
